// File: rtl/accum_reg.sv
// Accumulates COUNT accepted d beats into an ACCWIDTH-bit total behind a valid/ready handshake.
// Optional build macro ACCUM_SATURATE_EN: clamp to all-ones on carry instead of wrapping.
module accum_reg #(
  parameter int DATAWIDTH = 2,
  parameter int ACCWIDTH  = 8,
  parameter int COUNT     = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 clr,
  input  logic [DATAWIDTH-1:0] d,
  input  logic                 dValid,
  output logic                 dReady,
  output logic [ACCWIDTH-1:0]  q,
  output logic                 qValid,
  input  logic                 qReady,
  output logic                 ovf
);
  localparam int CW = $clog2(COUNT) + 1;
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t              state;
  logic [ACCWIDTH-1:0] acc;
  logic [CW-1:0]       cnt;
  logic                ovf_int;

  logic [ACCWIDTH-1:0] d_ext;
  logic [ACCWIDTH:0]   sum;
  logic                carry;
  logic [ACCWIDTH-1:0] acc_nxt;
  logic                in_xfer, out_xfer;

  assign d_ext = ACCWIDTH'(d);
  assign sum   = {1'b0, acc} + {1'b0, d_ext};
  assign carry = sum[ACCWIDTH];
`ifdef ACCUM_SATURATE_EN
  // Once clamped, later adds keep carrying (or add zero), so the clamp persists.
  assign acc_nxt = carry ? {ACCWIDTH{1'b1}} : sum[ACCWIDTH-1:0];
`else
  assign acc_nxt = sum[ACCWIDTH-1:0];
`endif

  // qReady feeds dReady so a new frame can start while the held result drains.
  assign dReady   = Rst && !clr && ((state != HOLD) || qReady);
  assign in_xfer  = dValid && dReady;
  assign out_xfer = qValid && qReady;

  always_ff @(posedge Clk) begin
    if (!Rst || clr) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      ovf_int <= 1'b0;
      q       <= '0;
      qValid  <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (state == HOLD && out_xfer) begin
            qValid <= 1'b0;
            state  <= IDLE;
          end
          // First beat of a frame; in HOLD this overrides the drain above.
          if (in_xfer) begin
            acc     <= d_ext;
            cnt     <= CW'(1);
            ovf_int <= 1'b0;
            ovf     <= 1'b0;
            if (COUNT == 1) begin
              q      <= d_ext;
              qValid <= 1'b1;
              state  <= HOLD;
            end else begin
              qValid <= 1'b0;
              state  <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_xfer) begin
            acc     <= acc_nxt;
            cnt     <= cnt + CW'(1);
            ovf_int <= ovf_int | carry;
            if (cnt == LAST) begin
              q      <= acc_nxt;
              ovf    <= ovf_int | carry;
              qValid <= 1'b1;
              state  <= HOLD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_accum_reg.sv
// Bench for accum_reg: directed vector table, random run against a frame model, COUNT=1 sequence.
module tb_accum_reg;
  localparam int DW   = 4;
  localparam int AW   = 5;
  localparam int CNT  = 4;
  localparam int MAXV = (1 << AW) - 1;
`ifdef ACCUM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int OVQ = SAT ? 31 : 28;

  logic          Clk = 1'b0;
  logic          Rst, clr, dValid, qReady;
  logic [DW-1:0] d;
  logic          dReady, qValid, ovf;
  logic [AW-1:0] q;

  logic          rst1, dv1, qr1, clr1;
  logic [DW-1:0] d1;
  logic          drdy1, qv1, ovf1;
  logic [AW-1:0] q1;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  accum_reg #(.DATAWIDTH(DW), .ACCWIDTH(AW), .COUNT(CNT)) dut (
    .Clk(Clk), .Rst(Rst), .clr(clr), .d(d), .dValid(dValid), .dReady(dReady),
    .q(q), .qValid(qValid), .qReady(qReady), .ovf(ovf));

  accum_reg #(.DATAWIDTH(DW), .ACCWIDTH(AW), .COUNT(1)) dut1 (
    .Clk(Clk), .Rst(rst1), .clr(clr1), .d(d1), .dValid(dv1), .dReady(drdy1),
    .q(q1), .qValid(qv1), .qReady(qr1), .ovf(ovf1));

  typedef struct {
    bit rst; bit clr; bit dv; int d; bit qr;
    bit rdy; bit qv; int q; bit ovf;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(bit r, bit c, bit v, int dd, bit qr, bit rdy, bit qv, int qq, bit ov);
    vecs.push_back('{r, c, v, dd, qr, rdy, qv, qq, ov});
  endtask

  // Frame-level reference: collect beats, result is the plain integer sum.
  int  beats[$];
  bit  m_hold;
  int  m_q, m_ovf;

  function automatic int frame_sum();
    int s = 0;
    foreach (beats[i]) s += beats[i];
    return s;
  endfunction

  initial begin
    int  s;
    bit  exp_rdy;
    int  last_d;

    Rst = 0; clr = 0; dValid = 0; d = '0; qReady = 0;
    rst1 = 0; clr1 = 0; dv1 = 0; d1 = '0; qr1 = 0;

    for (int k = 0; k < 3; k++) add(0, 0, 1, 5, 1, 0, 0, 0, 0);
    add(1, 0, 1, 3, 1, 1, 0, 0, 0);
    add(1, 0, 1, 5, 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1, 0, 0, 0);
    add(1, 0, 1, 7, 1, 1, 0, 0, 0);
    add(1, 0, 1, 1, 0, 1, 1, 16, 0);
    for (int k = 0; k < 5; k++) add(1, 0, 1, 9, 0, 0, 1, 16, 0);
    for (int k = 0; k < 3; k++) add(1, 0, 1, 2, 1, 1, 0, 16, 0);
    add(1, 0, 1, 2, 1, 1, 1, 8, 0);
    for (int k = 0; k < 3; k++) add(1, 0, 1, 15, 1, 1, 0, 8, 0);
    add(1, 0, 1, 15, 1, 1, 1, OVQ, 1);
    for (int k = 0; k < 3; k++) add(1, 0, 1, 1, 1, 1, 0, OVQ, 0);
    add(1, 0, 1, 1, 1, 1, 1, 4, 0);
    for (int k = 0; k < 2; k++) add(1, 0, 1, 4, 1, 1, 0, 4, 0);
    add(1, 1, 1, 4, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) add(1, 0, 1, 1, 1, 1, 0, 0, 0);
    add(1, 0, 1, 1, 1, 1, 1, 4, 0);

    foreach (vecs[i]) begin
      Rst = vecs[i].rst; clr = vecs[i].clr; dValid = vecs[i].dv;
      d = DW'(vecs[i].d); qReady = vecs[i].qr;
      @(negedge Clk);
      chk($sformatf("vec%0d dReady", i), 32'(dReady), 32'(vecs[i].rdy));
      @(posedge Clk); #1;
      chk($sformatf("vec%0d qValid", i), 32'(qValid), 32'(vecs[i].qv));
      chk($sformatf("vec%0d q", i), 32'(q), 32'(vecs[i].q));
      chk($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].ovf));
    end

    // Random traffic against the frame model.
    Rst = 0; clr = 0; dValid = 0; qReady = 0;
    @(posedge Clk); #1;
    chk("rand reset q", 32'(q), 0);
    beats.delete(); m_hold = 0; m_q = 0; m_ovf = 0;
    Rst = 1;
    for (int c = 0; c < 600; c++) begin
      dValid = ($urandom_range(0, 3) != 0);
      d      = DW'($urandom_range(0, 15));
      qReady = ($urandom_range(0, 2) != 0);
      clr    = ($urandom_range(0, 39) == 0);
      exp_rdy = !clr && (!m_hold || qReady);
      @(negedge Clk);
      chk($sformatf("rand%0d dReady", c), 32'(dReady), 32'(exp_rdy));
      @(posedge Clk);
      if (clr) begin
        beats.delete(); m_hold = 0; m_q = 0; m_ovf = 0;
      end else begin
        if (m_hold && qReady) m_hold = 0;
        if (dValid && exp_rdy) begin
          if (beats.size() == 0) m_ovf = 0;
          beats.push_back(int'(d));
          if (beats.size() == CNT) begin
            s      = frame_sum();
            m_ovf  = (s > MAXV);
            m_q    = SAT ? ((s > MAXV) ? MAXV : s) : (s % (MAXV + 1));
            m_hold = 1;
            beats.delete();
          end
        end
      end
      #1;
      chk($sformatf("rand%0d qValid", c), 32'(qValid), 32'(m_hold));
      chk($sformatf("rand%0d q", c), 32'(q), 32'(m_q));
      chk($sformatf("rand%0d ovf", c), 32'(ovf), 32'(m_ovf));
    end
    clr = 0;

    // COUNT=1: each beat becomes the result on the next cycle.
    rst1 = 0; dv1 = 1; d1 = 4'd5; qr1 = 1;
    @(negedge Clk);
    chk("c1 reset dReady", 32'(drdy1), 0);
    @(posedge Clk); #1;
    chk("c1 reset qValid", 32'(qv1), 0);
    chk("c1 reset q", 32'(q1), 0);
    rst1 = 1;
    last_d = 0;
    for (int k = 0; k < 8; k++) begin
      d1 = DW'($urandom_range(0, 15));
      last_d = int'(d1);
      @(negedge Clk);
      chk($sformatf("c1 beat%0d dReady", k), 32'(drdy1), 1);
      @(posedge Clk); #1;
      chk($sformatf("c1 beat%0d qValid", k), 32'(qv1), 1);
      chk($sformatf("c1 beat%0d q", k), 32'(q1), 32'(last_d));
    end
    qr1 = 0; d1 = 4'd9;
    @(negedge Clk);
    chk("c1 hold dReady", 32'(drdy1), 0);
    @(posedge Clk); #1;
    chk("c1 hold q", 32'(q1), 32'(last_d));
    chk("c1 hold qValid", 32'(qv1), 1);
    rst1 = 0;
    @(posedge Clk); #1;
    chk("c1 rst-in-hold qValid", 32'(qv1), 0);
    chk("c1 rst-in-hold q", 32'(q1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
